// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer:
// opcodes, bus-encoder bit indices, state and opcode-class encodings.
package cpu_defs;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int ENC_ZLO = 19;
    localparam int ENC_PC  = 20;
    localparam int ENC_MDR = 21;
    localparam int ENC_C   = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_RFMT,
        CL_IMM,
        CL_NOP,
        CL_HALT,
        CL_ILL
    } op_class_e;

    function automatic op_class_e op_class(logic [4:0] op);
        op_class_e cls;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                cls = CL_RFMT;
            OP_ADDI, OP_ANDI, OP_ORI:
                cls = CL_IMM;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: cls = CL_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index to one-hot 16-bit select, gated by an enable.
module reg_select_decoder (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) sel_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM driving DataPath: fetch in T0-T2, execute
// R-format / immediate ALU, nop and halt in T3-T5.
module control_sequencer
    import cpu_defs::*;
#(
    parameter bit RESET_PC_HOLD = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [23:0] bus_encoder_signals,
    output logic [15:0] r_in,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        illegal
);

    state_e    state_q, state_d;
    op_class_e cls;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [3:0]  out_idx;
    logic        out_en, in_en;
    logic [15:0] out_sel;
    logic [23:0] enc;
    logic        unused_bits;

    assign op  = ir[31:27];
    assign ra  = ir[26:23];
    assign rb  = ir[22:19];
    assign rc  = ir[18:15];
    assign cls = op_class(op);

    // Immediate field is consumed by DataPath; the hold mode is fixed on.
    assign unused_bits = ^{ir[14:0], RESET_PC_HOLD};

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        enc     = '0;
        out_idx = rb;
        out_en  = 1'b0;
        in_en   = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        opcode  = '0;
        illegal = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                enc[ENC_PC] = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                enc[ENC_ZLO] = 1'b1;
                PCin  = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                enc[ENC_MDR] = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                unique case (cls)
                    CL_RFMT, CL_IMM: begin
                        out_en  = 1'b1;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    CL_HALT: state_d = S_HALT;
                    CL_NOP:  state_d = S_T0;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_T0;
                    end
                endcase
            end
            S_T4: begin
                // R-format takes rc from the register file, immediates use C.
                if (cls == CL_RFMT) begin
                    out_idx = rc;
                    out_en  = 1'b1;
                end else begin
                    enc[ENC_C] = 1'b1;
                end
                opcode  = op;
                Zin     = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                enc[ENC_ZLO] = 1'b1;
                in_en   = 1'b1;
                state_d = S_T0;
            end
            S_HALT: if (start) state_d = S_T0;
            default: state_d = S_IDLE;
        endcase
    end

    reg_select_decoder u_out_dec (
        .idx_i (out_idx),
        .en_i  (out_en),
        .sel_o (out_sel)
    );

    reg_select_decoder u_in_dec (
        .idx_i (ra),
        .en_i  (in_en),
        .sel_o (r_in)
    );

    assign bus_encoder_signals = enc | {8'b0, out_sel};
    assign run = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `DataPath` and drives its bus-encoder, register-enable, memory and ALU-opcode controls. It replaces hand-sequenced bench stimulus with a Moore state machine. The machine runs instruction fetch (T0–T2) and then executes R-format ALU, immediate ALU, `nop` and `halt` instructions (T3–T5). It reads the instruction from the IR contents that `DataPath` exposes.

## Interface
- `RESET_PC_HOLD`, default 0 — when 1, the machine stays in IDLE after reset until `start` (always used; kept as a parameter for future auto-run).
- `clock` in 1 — single system clock; all state changes on the rising edge.
- `clear` in 1 — reset, synchronous and active-high.
- `start` in 1 — leave IDLE or HALT and begin fetch.
- `ir` in 32 — IR register contents from `DataPath`.
- `mem_ready` in 1 — memory data valid this cycle; ends the T1 wait.
- `bus_encoder_signals` out 24 — one-hot bus source:
  - [15:0] R0–R15 out
  - 16 HIout, 17 LOout, 18 Zhighout, 19 Zlowout, 20 PCout, 21 MDRout, 22 Inport out, 23 Cout
- `r_in` out 16 — R0–R15 load enables.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `IncPC`, `Read` out 1 each — `DataPath` enables.
- `opcode` out 5 — ALU operation select.
- `run` out 1 — high in every state except IDLE and HALT.
- `illegal` out 1 — one-cycle pulse on an unsupported opcode.

## Operation
- IR fields:
  - op = `ir[31:27]`
  - ra = `ir[26:23]`
  - rb = `ir[22:19]`
  - rc = `ir[18:15]`
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- Transitions:
  - IDLE→T0 on `start`.
  - T0→T1.
  - T1→T2 when `mem_ready`; otherwise stay in T1.
  - T2→T3.
  - T3→T4→T5→T0 for ALU classes.
  - T3→T0 for `nop` and illegal opcodes.
  - T3→HALT for `halt`.
  - HALT→T0 on `start`.
- Outputs are a pure function of the registered state and `ir` (Moore). Unlisted outputs are 0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. PC reload is idempotent while waiting.
  - T2: MDRout, IRin.
  - R-format ALU (op 00011–01011: add, sub, and, or, ror, rol, shr, shra, shl):
    - T3: R[rb]out, Yin.
    - T4: R[rc]out, `opcode`=op, Zin.
    - T5: Zlowout, `r_in`[ra].
  - Immediate ALU (op 01100 addi, 01101 andi, 01110 ori):
    - T3: R[rb]out, Yin.
    - T4: Cout, `opcode`=op, Zin. `DataPath` sign-extends `ir[18:0]`.
    - T5: Zlowout, `r_in`[ra].
  - `nop` 11010: T3 drives no outputs.
  - `halt` 11011: T3 drives no outputs.
  - Any other op: T3 asserts `illegal` for one cycle and nothing else.
- `bus_encoder_signals` carries at most one set bit in every state. `r_in` carries at most one set bit.
- Register index decode: 4-bit index to one-hot 16-bit.

## Timing
- `clear` high at an edge forces IDLE on that edge, regardless of state, including mid-T1 wait. All outputs then read 0, including `run`.
- Latency from `start` to first T0 outputs: 1 cycle.
- Fetch takes 3 cycles plus the T1 wait cycles.
- R-format and immediate instructions take 6 cycles total with zero wait.
- `nop` and illegal take 4 cycles.
- `start` is ignored outside IDLE and HALT.
- If `mem_ready` is already high on T1 entry, T1 lasts exactly one cycle.
- `ir` is sampled combinationally from T3 onward. It is stable because `IRin` is asserted only in T2.

## Structure
- A shared package `cpu_defs` holds:
  - opcode constants (`OP_ADD`=5'b00011 … `OP_HALT`=5'b11011);
  - encoder bit indices (`ENC_ZLO`=19, `ENC_PC`=20, `ENC_MDR`=21, `ENC_C`=23);
  - the state encoding.
- One sub-module, `reg_select_decoder`, maps a 4-bit index plus enable to a one-hot 16-bit vector. It is instantiated twice: once for the out path and once for the in path.

## Test plan
- **Reset/start.** `clear`=1 for 2 cycles, then 0 → all outputs 0, `run`=0. Pulse `start` → next cycle PCout=1, MARin=1, IncPC=1, Zin=1.
- **`and r1,r2,r3`.** `ir`=32'h28918000 with `mem_ready`=1:
  - T3: `bus_encoder_signals`=24'h000004, Yin=1.
  - T4: 24'h000008, `opcode`=5'b00101.
  - T5: bit 19 set, `r_in`=16'h0002.
  - Then T0.
- **Memory wait.** Hold `mem_ready`=0 for 3 cycles in T1 → Read and MDRin stay 1 for 4 cycles; T2 follows the cycle after `mem_ready` rises.
- **`addi r4,r5,-3`.** `ir`=32'h622FFFFD:
  - T4: `bus_encoder_signals`=24'h800000, `opcode`=5'b01100.
  - T5: `r_in`=16'h0010.
- **Halt/illegal.**
  - `ir` op 11011 → HALT with `run`=0; `start` resumes at T0.
  - `ir` op 11111 → `illegal` pulses once in T3, then T0.
- **Reset mid-wait.** `clear`=1 during a T1 wait → IDLE next edge, Read=0.
